// File: rtl/pbs_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Holds the operation encodings and the op_t type used by pipe_barrel_shifter
// and pbs_stage.
package pbs_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,  // logical left, zero fill
    OP_SRL = 2'b01,  // logical right, zero fill
    OP_SRA = 2'b10,  // arithmetic right, sign fill
    OP_ROR = 2'b11   // rotate right (behaves as SRL when rotate is compiled out)
  } op_t;

endpackage

// File: rtl/pbs_stage.sv
// One stage of the pipelined barrel shifter.
// Stage K shifts its operand by 2**K when bit K of the carried shift amount is
// set, otherwise the operand passes through unchanged. The stage registers
// valid, data, op and shift amount and advances only when adv is high.
// Data, op and shamt are loaded only for valid entries, so a bubble moving
// through leaves the previous data in place (out_data holds its last value).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   adv                pipeline advance enable (common to all stages)
//   prev_vld/data/op/shamt  contents of the preceding stage (or the input)
//   vld/data/op/shamt       registered contents of this stage
//
// Macro PIPE_BARREL_SHIFTER_ROTATE_EN: when defined, OP_ROR wraps the bits
// shifted out of the bottom into the top; otherwise OP_ROR is a logical right
// shift and no wrap path exists.
module pbs_stage
  import pbs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  input  op_t              prev_op,
  input  logic [SHW-1:0]   prev_shamt,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output op_t              op,
  output logic [SHW-1:0]   shamt
);

  localparam int unsigned DIST = 2 ** K;

  logic signed [WIDTH-1:0] sdata;
  logic        [WIDTH-1:0] shifted;
  logic        [WIDTH-1:0] nxt;

  // An arithmetic right shift never changes the MSB, so the current MSB at
  // any stage is still the original operand's sign bit.
  always_comb begin
    sdata   = prev_data;
    shifted = prev_data;
    case (prev_op)
      OP_SLL:  shifted = prev_data << DIST;
      OP_SRA:  shifted = sdata >>> DIST;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
      OP_ROR:  shifted = {prev_data[DIST-1:0], prev_data[WIDTH-1:DIST]};
`endif
      default: shifted = prev_data >> DIST;
    endcase
    nxt = prev_shamt[K] ? shifted : prev_data;
  end

  // ---- stage K register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= 1'b0;
      data  <= '0;
      op    <= OP_SLL;
      shamt <= '0;
    end else if (adv) begin
      vld <= prev_vld;
      if (prev_vld) begin
        data  <= nxt;
        op    <= prev_op;
        shamt <= prev_shamt;
      end
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready handshake on both sides.
// SHW = log2(WIDTH) registered stages; stage k handles shift-amount bit k.
// Latency is SHW cycles, throughput one operation per cycle. All stages move
// together when adv = !out_valid || out_ready, and all hold otherwise, so a
// full pipeline can retire and accept in the same cycle.
//
// Ports:
//   clk        clock (rising edge)
//   rst        asynchronous active-high reset, clears every stage
//   in_valid   request valid
//   in_ready   request accepted when high with in_valid (equals adv)
//   in_data    operand, WIDTH bits
//   shamt      shift amount, SHW bits
//   op         00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   shifted result, held while stalled and while out_valid is low
//
// Macro PIPE_BARREL_SHIFTER_ROTATE_EN: defined -> op 11 rotates right;
// undefined -> op 11 executes as SRL.
module pipe_barrel_shifter
  import pbs_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             adv;
  logic             vld_p   [SHW+1];
  logic [WIDTH-1:0] data_p  [SHW+1];
  op_t              op_p    [SHW+1];
  logic [SHW-1:0]   shamt_p [SHW+1];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Index 0 is the unregistered request; index k+1 is the output of stage k.
  assign vld_p[0]   = in_valid;
  assign data_p[0]  = in_data;
  assign op_p[0]    = op_t'(op);
  assign shamt_p[0] = shamt;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    // ---- stage k boundary ----
    pbs_stage #(
      .WIDTH (WIDTH),
      .K     (k),
      .SHW   (SHW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .prev_vld   (vld_p[k]),
      .prev_data  (data_p[k]),
      .prev_op    (op_p[k]),
      .prev_shamt (shamt_p[k]),
      .vld        (vld_p[k+1]),
      .data       (data_p[k+1]),
      .op         (op_p[k+1]),
      .shamt      (shamt_p[k+1])
    );
  end

  assign out_valid = vld_p[SHW];
  assign out_data  = data_p[SHW];

  // The last stage's op and shamt have no consumer; reduce them to a sink.
  logic unused_tail;
  assign unused_tail = ^{op_p[SHW], shamt_p[SHW]};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter (WIDTH = 8).
// Directed vectors, stall/hold, back-to-back throughput, randomized traffic
// against a queue-based reference model, and asynchronous reset mid-flight.
module tb_pipe_barrel_shifter;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] shamt;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  int n_chk       = 0;
  int n_pass      = 0;
  int cycle_no    = 0;
  int n_deliv     = 0;
  int first_deliv = -1;
  int last_deliv  = -1;

  logic [W-1:0] exp_q[$];

  pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference: the whole shift in one step from the operation's definition.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                         input logic [1:0] o);
    logic [2*W-1:0] w;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
      default: begin
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
        w = {d, d} >> s;
`else
        w = {{W{1'b0}}, d} >> s;
`endif
        return w[W-1:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Called at posedge+1 with inputs already driven; scores the handshakes
  // that the next edge will perform, then returns at the next posedge+1.
  task automatic cyc();
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(in_data, int'(shamt), op));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_valid, 0);
      else chk("result", out_data, exp_q.pop_front());
      n_deliv++;
      if (first_deliv < 0) first_deliv = cycle_no;
      last_deliv = cycle_no;
    end
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  // Single operation into an empty pipeline; reports edges until out_valid.
  task automatic run_op(input logic [W-1:0] d, input logic [SW-1:0] s,
                        input logic [1:0] o, output logic [W-1:0] res, output int lat);
    in_valid = 1'b1; in_data = d; shamt = s; op = o; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    res = out_data;
    cyc();
  endtask

  logic [W-1:0]  d_in  [7];
  logic [SW-1:0] d_sh  [7];
  logic [1:0]    d_op  [7];
  logic [W-1:0]  d_exp [7];

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] hold;
    int lat, w, n0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; shamt = '0; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    d_in[0] = 8'b10001011; d_sh[0] = 3'd3; d_op[0] = 2'b00; d_exp[0] = 8'b01011000;
    d_in[1] = 8'b10001011; d_sh[1] = 3'd4; d_op[1] = 2'b01; d_exp[1] = 8'b00001000;
    d_in[2] = 8'b10001011; d_sh[2] = 3'd4; d_op[2] = 2'b10; d_exp[2] = 8'b11111000;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
    d_in[3] = 8'b10001011; d_sh[3] = 3'd3; d_op[3] = 2'b11; d_exp[3] = 8'b01110001;
`else
    d_in[3] = 8'b10001011; d_sh[3] = 3'd4; d_op[3] = 2'b11; d_exp[3] = 8'b00001000;
`endif
    for (int i = 4; i < 7; i++) begin
      d_in[i] = 8'hA5; d_sh[i] = 3'd0; d_op[i] = 2'(i - 4); d_exp[i] = 8'hA5;
    end
    for (int i = 0; i < 7; i++) begin
      run_op(d_in[i], d_sh[i], d_op[i], res, lat);
      chk($sformatf("latency_%0d", i), lat, 3);
      chk($sformatf("directed_%0d", i), res, d_exp[i]);
    end
    run_op(8'hA5, 3'd0, 2'b11, res, lat);
    chk("ror_sh0", res, 8'hA5);

    // Stall: three back-to-back accepts, then consumer blocks for 5 cycles.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); shamt = SW'($urandom); op = 2'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin cyc(); w++; end
    chk("stall_fill", out_valid, 1);
    hold = out_data;
    repeat (5) begin
      in_valid = 1'b1;
      cyc();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", out_data, hold);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n0 = n_deliv;
    repeat (3) begin
      chk("release_valid", out_valid, 1);
      cyc();
    end
    chk("release_count", n_deliv - n0, 3);

    // Throughput: 10 operands with both sides always ready.
    n0 = n_deliv; first_deliv = -1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); shamt = SW'($urandom); op = 2'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    w = 0;
    while (exp_q.size() > 0 && w < 20) begin cyc(); w++; end
    chk("tput_count", n_deliv - n0, 10);
    chk("tput_span", last_deliv - first_deliv, 9);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      shamt     = SW'($urandom);
      op        = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    w = 0;
    while (exp_q.size() > 0 && w < 20) begin cyc(); w++; end
    chk("drain_empty", exp_q.size(), 0);

    // Asynchronous reset mid-cycle with work in flight and a result waiting.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h81; shamt = 3'd0; op = 2'b00;
    cyc();
    in_data = 8'h3C; shamt = 3'd1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (8) begin
      chk("post_rst_valid", out_valid, 0);
      cyc();
    end
    run_op(8'hA5, 3'd1, 2'b10, res, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_sra", res, 8'hD2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
